// File: rtl/dcmi_pkg.sv
// Shared DCMI definitions: data width and receiver state encoding.
package dcmi_pkg;
  localparam int DCMI_DATA_W = 8;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    RECV      = 2'd2,
    DONE      = 2'd3
  } rx_state_e;
endpackage

// File: rtl/dcmi_rx_sync.sv
// Synchronizes DCLK/DATA/DSYNC into CLK through equal-depth chains and
// emits a one-cycle sample strobe on the synchronized DCLK rising edge.
module dcmi_rx_sync
  import dcmi_pkg::*;
#(
  parameter int SYNC_FF = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   DCLK,
  input  logic [DCMI_DATA_W-1:0] DATA,
  input  logic                   DSYNC,
  output logic                   sample,
  output logic [DCMI_DATA_W-1:0] s_data,
  output logic                   s_dsync
);

  logic [SYNC_FF-1:0]     clk_sync_q, clk_sync_d;
  logic [SYNC_FF-1:0]     dsync_sync_q, dsync_sync_d;
  logic [DCMI_DATA_W-1:0] data_sync_q [SYNC_FF];
  logic [DCMI_DATA_W-1:0] data_sync_d [SYNC_FF];
  logic                   clk_prev_q, clk_prev_d;

  always_comb begin
    clk_sync_d[0]   = DCLK;
    dsync_sync_d[0] = DSYNC;
    data_sync_d[0]  = DATA;
    for (int i = 1; i < SYNC_FF; i++) begin
      clk_sync_d[i]   = clk_sync_q[i-1];
      dsync_sync_d[i] = dsync_sync_q[i-1];
      data_sync_d[i]  = data_sync_q[i-1];
    end
    clk_prev_d = clk_sync_q[SYNC_FF-1];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      clk_sync_q   <= '0;
      dsync_sync_q <= '0;
      clk_prev_q   <= 1'b0;
      for (int i = 0; i < SYNC_FF; i++) data_sync_q[i] <= '0;
    end else begin
      clk_sync_q   <= clk_sync_d;
      dsync_sync_q <= dsync_sync_d;
      clk_prev_q   <= clk_prev_d;
      for (int i = 0; i < SYNC_FF; i++) data_sync_q[i] <= data_sync_d[i];
    end
  end

  // DATA and DSYNC are taken from the same stage as the detected edge.
  assign sample  = clk_sync_q[SYNC_FF-1] & ~clk_prev_q;
  assign s_data  = data_sync_q[SYNC_FF-1];
  assign s_dsync = dsync_sync_q[SYNC_FF-1];

endmodule

// File: rtl/dcmi_rx_buffer.sv
// DCMI slave receiver: captures one DSYNC frame into a RAM and serves it
// via a sequential read port. Define DCMI_RX_STATS_EN for frame/drop counters.
module dcmi_rx_buffer
  import dcmi_pkg::*;
#(
  parameter int LEN_BITS = 10,
  parameter int SYNC_FF  = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   DCLK,
  input  logic [DCMI_DATA_W-1:0] DATA,
  input  logic                   DSYNC,
  output logic                   RX_READY,
  output logic [LEN_BITS:0]      RX_LEN,
  output logic                   RX_OVF,
  input  logic                   RD,
  input  logic                   RD_RST,
  output logic [DCMI_DATA_W-1:0] DO,
  input  logic                   ACK,
`ifdef DCMI_RX_STATS_EN
  output logic [15:0]            FRAME_CNT,
  output logic [15:0]            DROP_CNT,
`endif
  output rx_state_e              dbg_state
);

  localparam int                DEPTH    = 2**LEN_BITS;
  localparam logic [LEN_BITS:0] CNT_ONE  = 1;
  localparam logic [LEN_BITS-1:0] ADDR_ONE = 1;

  logic                   sample, s_dsync;
  logic [DCMI_DATA_W-1:0] s_data;

  dcmi_rx_sync #(.SYNC_FF(SYNC_FF)) u_sync (
    .CLK     (CLK),
    .RST     (RST),
    .DCLK    (DCLK),
    .DATA    (DATA),
    .DSYNC   (DSYNC),
    .sample  (sample),
    .s_data  (s_data),
    .s_dsync (s_dsync)
  );

  rx_state_e             state_q, state_d;
  logic [LEN_BITS:0]     wr_cnt_q, wr_cnt_d;
  logic [LEN_BITS:0]     rx_len_q, rx_len_d;
  logic                  rx_ready_q, rx_ready_d;
  logic                  rx_ovf_q, rx_ovf_d;
  logic                  fin_q, fin_d;
  logic [LEN_BITS-1:0]   rd_addr_q, rd_addr_d;
  logic                  we;
  logic [LEN_BITS-1:0]   wr_addr;
  logic [DCMI_DATA_W-1:0] mem [DEPTH];
  logic [DCMI_DATA_W-1:0] do_q;

  always_comb begin
    state_d    = state_q;
    wr_cnt_d   = wr_cnt_q;
    rx_len_d   = rx_len_q;
    rx_ready_d = rx_ready_q;
    rx_ovf_d   = rx_ovf_q;
    fin_d      = 1'b0;
    we         = 1'b0;
    wr_addr    = wr_cnt_q[LEN_BITS-1:0];
    case (state_q)
      WAIT_IDLE: if (sample && !s_dsync) state_d = IDLE;
      IDLE: if (sample && s_dsync) begin
        we       = 1'b1;
        wr_addr  = '0;
        wr_cnt_d = CNT_ONE;
        state_d  = RECV;
      end
      RECV: begin
        // fin_q delays RX_READY one cycle after the length is latched.
        if (fin_q) begin
          rx_ready_d = 1'b1;
          state_d    = DONE;
        end else if (sample) begin
          if (s_dsync) begin
            if (!wr_cnt_q[LEN_BITS]) begin
              we       = 1'b1;
              wr_cnt_d = wr_cnt_q + CNT_ONE;
            end else begin
              rx_ovf_d = 1'b1;
            end
          end else begin
            rx_len_d = wr_cnt_q;
            fin_d    = 1'b1;
          end
        end
      end
      DONE: if (ACK) begin
        rx_ready_d = 1'b0;
        rx_ovf_d   = 1'b0;
        wr_cnt_d   = '0;
        state_d    = WAIT_IDLE;
      end
      default: state_d = WAIT_IDLE;
    endcase

    rd_addr_d = rd_addr_q;
    if (RD_RST)  rd_addr_d = '0;
    else if (RD) rd_addr_d = rd_addr_q + ADDR_ONE;
    if (state_q == DONE && ACK) rd_addr_d = '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= WAIT_IDLE;
      wr_cnt_q   <= '0;
      rx_len_q   <= '0;
      rx_ready_q <= 1'b0;
      rx_ovf_q   <= 1'b0;
      fin_q      <= 1'b0;
      rd_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      rx_len_q   <= rx_len_d;
      rx_ready_q <= rx_ready_d;
      rx_ovf_q   <= rx_ovf_d;
      fin_q      <= fin_d;
      rd_addr_q  <= rd_addr_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (we) mem[wr_addr] <= s_data;
  end

  // RD_RST takes priority: the read is suppressed and DO holds.
  always_ff @(posedge CLK) begin
    if (RST)                 do_q <= '0;
    else if (RD && !RD_RST)  do_q <= mem[rd_addr_q];
  end

`ifdef DCMI_RX_STATS_EN
  localparam logic [15:0] STAT_ONE = 16'd1;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        last_dsync_q, last_dsync_d;

  always_comb begin
    frame_cnt_d  = frame_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    last_dsync_d = sample ? s_dsync : last_dsync_q;
    if (state_q == RECV && fin_q) frame_cnt_d = frame_cnt_q + STAT_ONE;
    if (state_q == DONE && sample && s_dsync && !last_dsync_q)
      drop_cnt_d = drop_cnt_q + STAT_ONE;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      frame_cnt_q  <= '0;
      drop_cnt_q   <= '0;
      last_dsync_q <= 1'b0;
    end else begin
      frame_cnt_q  <= frame_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      last_dsync_q <= last_dsync_d;
    end
  end

  assign FRAME_CNT = frame_cnt_q;
  assign DROP_CNT  = drop_cnt_q;
`endif

  assign RX_READY  = rx_ready_q;
  assign RX_LEN    = rx_len_q;
  assign RX_OVF    = rx_ovf_q;
  assign DO        = do_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dcmi_rx_buffer.sv
// Bench for dcmi_rx_buffer: DCMI master driven at CLK/8, frames compared
// against a byte-array model of the capture buffer and read pointer.
module tb_dcmi_rx_buffer;
  import dcmi_pkg::*;

  localparam int LB    = 4;
  localparam int DEPTH = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          DCLK = 1'b0;
  logic [7:0]    DATA = '0;
  logic          DSYNC = 1'b0;
  logic          RX_READY;
  logic [LB:0]   RX_LEN;
  logic          RX_OVF;
  logic          RD = 1'b0;
  logic          RD_RST = 1'b0;
  logic [7:0]    DO;
  logic          ACK = 1'b0;
  rx_state_e     dbg_state;
`ifdef DCMI_RX_STATS_EN
  logic [15:0]   FRAME_CNT, DROP_CNT;
`endif

  dcmi_rx_buffer #(.LEN_BITS(LB), .SYNC_FF(2)) dut (
    .CLK(CLK), .RST(RST), .DCLK(DCLK), .DATA(DATA), .DSYNC(DSYNC),
    .RX_READY(RX_READY), .RX_LEN(RX_LEN), .RX_OVF(RX_OVF),
    .RD(RD), .RD_RST(RD_RST), .DO(DO), .ACK(ACK),
`ifdef DCMI_RX_STATS_EN
    .FRAME_CNT(FRAME_CNT), .DROP_CNT(DROP_CNT),
`endif
    .dbg_state(dbg_state)
  );

  // clock/reset block
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model
  logic [7:0] mod_mem [DEPTH];
  bit         mod_val [DEPTH];
  int         exp_len   = 0;
  bit         exp_ovf   = 0;
  int         exp_rd    = 0;
  logic [7:0] exp_do    = 8'h00;
  bit         dut_done  = 0;
  int         exp_frames = 0;
  int         exp_drop  = 0;

  // driver tasks
  task automatic dclk_byte(input logic [7:0] d, input logic s);
    DATA  = d;
    DSYNC = s;
    repeat (4) @(negedge CLK);
    DCLK = 1'b1;
    repeat (4) @(negedge CLK);
    DCLK = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    for (int k = 0; k < 200 && RX_READY !== 1'b1; k++) @(negedge CLK);
    n_tests++;
    if (RX_READY !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready_timeout: RX_READY=%b required 1", tag, RX_READY);
    end
  endtask

  task automatic send_frame(input int n, input bit seq, input string tag);
    logic [7:0] b [$];
    for (int i = 0; i < n; i++) b.push_back(seq ? 8'(i) : 8'($urandom_range(0, 255)));
    dclk_byte(8'h00, 1'b0);
    foreach (b[i]) dclk_byte(b[i], 1'b1);
    dclk_byte(8'h00, 1'b0);
    dclk_byte(8'h00, 1'b0);
    if (dut_done) begin
      exp_drop++;
      repeat (10) @(negedge CLK);
    end else begin
      for (int i = 0; i < n && i < DEPTH; i++) begin
        mod_mem[i] = b[i];
        mod_val[i] = 1'b1;
      end
      exp_len = (n < DEPTH) ? n : DEPTH;
      exp_ovf = (n > DEPTH);
      exp_frames++;
      dut_done = 1;
      wait_ready(tag);
    end
  endtask

  task automatic check_frame(input string tag);
    n_tests++;
    if (RX_READY !== 1'b1 || RX_LEN !== (LB+1)'(exp_len) || RX_OVF !== exp_ovf) begin
      n_fail++;
      $display("FAIL %s status: ready=%b len=%0d ovf=%b required ready=1 len=%0d ovf=%b",
               tag, RX_READY, RX_LEN, RX_OVF, exp_len, exp_ovf);
    end
  endtask

  task automatic read_n(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      RD = 1'b1;
      @(negedge CLK);
      RD = 1'b0;
      if (mod_val[exp_rd]) begin
        exp_do = mod_mem[exp_rd];
        n_tests++;
        if (DO !== exp_do) begin
          n_fail++;
          $display("FAIL %s read[%0d]: DO=%h required %h", tag, exp_rd, DO, exp_do);
        end
      end else begin
        exp_do = DO;
      end
      exp_rd = (exp_rd + 1) % DEPTH;
    end
  endtask

  task automatic do_rd_rst();
    @(negedge CLK); RD_RST = 1'b1;
    @(negedge CLK); RD_RST = 1'b0;
    exp_rd = 0;
  endtask

  task automatic do_ack(input string tag);
    @(negedge CLK); ACK = 1'b1;
    @(negedge CLK); ACK = 1'b0;
    dut_done = 0;
    exp_rd   = 0;
    exp_ovf  = 0;
    n_tests++;
    if (RX_READY !== 1'b0 || RX_OVF !== 1'b0) begin
      n_fail++;
      $display("FAIL %s ack_clear: ready=%b ovf=%b required 0 0", tag, RX_READY, RX_OVF);
    end
  endtask

  task automatic apply_reset();
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    exp_len = 0; exp_ovf = 0; exp_rd = 0; exp_do = 8'h00;
    dut_done = 0; exp_frames = 0; exp_drop = 0;
  endtask

  // scenarios
  task automatic test_reset();
    for (int i = 0; i < DEPTH; i++) mod_val[i] = 1'b0;
    apply_reset();
    n_tests++;
    if (RX_READY !== 1'b0 || RX_LEN !== '0 || RX_OVF !== 1'b0 || DO !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b len=%0d ovf=%b do=%h required 0 0 0 00",
               RX_READY, RX_LEN, RX_OVF, DO);
    end
  endtask

  task automatic test_basic();
    send_frame(4, 1, "basic");
    check_frame("basic");
    read_n(4, "basic");
  endtask

  task automatic test_random();
    int lens [4] = '{16, 0, 0, 1};
    for (int t = 0; t < 4; t++) begin
      int n;
      n = (lens[t] != 0) ? lens[t] : int'($urandom_range(2, 15));
      do_ack("random");
      send_frame(n, 0, "random");
      check_frame("random");
      read_n(n + 3, "random");
    end
  endtask

  task automatic test_overflow();
    do_ack("ovf");
    send_frame(DEPTH + 3, 0, "ovf");
    check_frame("ovf");
    read_n(DEPTH, "ovf");
  endtask

  task automatic test_drop();
    send_frame(5, 0, "drop");
    check_frame("drop");
    do_rd_rst();
    read_n(DEPTH, "drop");
  endtask

  task automatic test_rd_rst_priority();
    do_rd_rst();
    read_n(2, "rdrst");
    @(negedge CLK); RD = 1'b1; RD_RST = 1'b1;
    @(negedge CLK); RD = 1'b0; RD_RST = 1'b0;
    exp_rd = 0;
    n_tests++;
    if (DO !== exp_do) begin
      n_fail++;
      $display("FAIL rdrst_hold: DO=%h required %h", DO, exp_do);
    end
    read_n(1, "rdrst");
  endtask

  task automatic test_ack_with_rd();
    do_rd_rst();
    read_n(2, "ackrd");
    @(negedge CLK); RD = 1'b1; ACK = 1'b1;
    @(negedge CLK); RD = 1'b0; ACK = 1'b0;
    exp_do = mod_mem[exp_rd];
    n_tests++;
    if (DO !== exp_do || RX_READY !== 1'b0) begin
      n_fail++;
      $display("FAIL ackrd: DO=%h ready=%b required %h 0", DO, RX_READY, exp_do);
    end
    dut_done = 0; exp_rd = 0; exp_ovf = 0;
    send_frame(6, 1, "ackrd");
    check_frame("ackrd");
    read_n(3, "ackrd");
  endtask

  task automatic test_reset_midframe();
    do_ack("midrst");
    dclk_byte(8'h00, 1'b0);
    dclk_byte(8'hA1, 1'b1);
    dclk_byte(8'hA2, 1'b1);
    apply_reset();
    for (int i = 0; i < 3; i++) dclk_byte(8'hB0 + 8'(i), 1'b1);
    dclk_byte(8'h00, 1'b0);
    dclk_byte(8'h00, 1'b0);
    repeat (30) @(negedge CLK);
    n_tests++;
    if (RX_READY !== 1'b0 || RX_LEN !== '0) begin
      n_fail++;
      $display("FAIL midrst_ignored: ready=%b len=%0d required 0 0", RX_READY, RX_LEN);
    end
    send_frame(4, 0, "midrst");
    check_frame("midrst");
    read_n(4, "midrst");
  endtask

  task automatic test_stats();
`ifdef DCMI_RX_STATS_EN
    send_frame(3, 0, "stats");
    n_tests++;
    if (FRAME_CNT !== 16'(exp_frames) || DROP_CNT !== 16'(exp_drop)) begin
      n_fail++;
      $display("FAIL stats: frames=%0d drops=%0d required %0d %0d",
               FRAME_CNT, DROP_CNT, exp_frames, exp_drop);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_overflow();
    test_drop();
    test_rd_rst_priority();
    test_ack_with_rd();
    test_reset_midframe();
    test_stats();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
